mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock for all state; reset input 1, synchronous active-high reset.
REQ-002 ic_req  input  1  I-cache line-fill request; held high until ic_ack is seen.
REQ-003 ic_line_addr  input  58  I-cache line address, 64-byte line.
REQ-004 ic_ack  output  1  one-cycle pulse: I-cache fill complete, line_rdata valid.
REQ-005 dc_req  input  1  D-cache line request; held high until dc_ack is seen.
REQ-006 dc_line_addr  input  58  D-cache line address.
REQ-007 dc_write  input  1  1 = writeback of dc_wline, 0 = line fill.
REQ-008 dc_wline  input  512  D-cache writeback line; beat k = bits [64k+63:64k].
REQ-009 dc_ack  output  1  one-cycle pulse: D-cache transaction complete.
REQ-010 line_rdata  output  512  assembled fill line, shared by both clients.
REQ-011 mem_req  output  1  address-phase request to backing memory.
REQ-012 mem_addr  output  64  byte address {line_addr, 6'b0}.
REQ-013 mem_we  output  1  1 = write burst.
REQ-014 mem_ready  input  1  memory accepts the address (ADDR state) or the write beat (BEAT state).
REQ-015 mem_wdata  output  64  current write beat.
REQ-016 mem_rvalid  input  1  read beat valid.
REQ-017 mem_rdata  input  64  read beat data.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement the states IDLE, ADDR, BEAT and RESP, with a 3-bit beat counter; every burst is exactly 8 beats.
REQ-020 IDLE: if either request is high, SHALL register the grant, latch the granted address/we/wline, clear the counter and go to ADDR; otherwise it SHALL stay in IDLE.
REQ-021 Arbitration SHALL follow these rules:
- one requester high: grant it.
- both high: grant the client not served last (round-robin).
- last_grant SHALL reset to IC, so DC wins the first tie.
- last_grant SHALL update on grant.
REQ-022 ADDR: mem_req=1, mem_addr and mem_we from the latched transaction; the block SHALL go to BEAT on mem_ready=1 and otherwise hold every output stable.
REQ-023 BEAT, read: on mem_rvalid=1, mem_rdata SHALL be written into line_rdata slice [64*cnt+63:64*cnt] and cnt incremented; with rvalid=0 the block SHALL hold.
REQ-024 BEAT, write: mem_wdata SHALL equal the latched wline slice cnt; the beat SHALL advance on mem_ready=1; with ready=0 the block SHALL hold the data.
REQ-025 When the beat with cnt=7 completes, the block SHALL go to RESP.
- Counter wrap 7->0 SHALL never be visible.
- mem_rvalid/mem_ready outside their state SHALL be ignored.
REQ-026 RESP: for exactly one cycle, the granted client's ack SHALL be 1, then the block SHALL go to IDLE; line_rdata SHALL hold until the next read's first beat.
REQ-027 Client contract: req SHALL be low in the cycle after its ack; the arbiter SHALL re-sample it in IDLE, with no extra dead cycle.
REQ-028 In ADDR, the latched address SHALL stay stable even if the requester changes its inputs.
REQ-029 A request arriving while busy SHALL wait; it SHALL NOT be dropped and SHALL NOT be acked.
REQ-030 ic_ack and dc_ack SHALL never be high together; mem_req SHALL be high only in ADDR.
REQ-031 Minimum latency: req in IDLE at cycle 0 gives ADDR at cycle 1, beats at cycles 2-9 and ack at cycle 10.
REQ-032 mem_we SHALL be 0 for IC transactions and for DC transactions with dc_write=0.

Reset
REQ-033 On reset=1 at a rising edge, from any state, the block SHALL return to IDLE with these values:
- last_grant=IC, cnt=0.
- latched address and wline = 0.
- all of ic_ack, dc_ack, mem_req, mem_we and busy = 0.
- mem_addr=0, mem_wdata=0, line_rdata=0.
REQ-034 A reset during ADDR or BEAT SHALL abort the transaction without an ack.

Verification
REQ-035 IC read only, addr 58'h1: mem_ready and rvalid are 1 every cycle, rdata = beat index.
- mem_addr=64'h40; ic_ack at cycle 10.
- line_rdata: beat k = 64'hk.
REQ-036 DC write, dc_line_addr=58'h3, wline beat k = 64'hA0+k, mem_ready low in every other cycle:
- mem_we=1.
- mem_wdata sequence A0..A7, each held while ready=0.
- dc_ack one cycle after the last accepted beat.
REQ-037 ic_req and dc_req rise in the same cycle after reset:
- DC is served first, then IC.
- A second simultaneous pair alternates starting from DC again, since DC was not last.
REQ-038 mem_rvalid pulses only every third cycle: cnt advances only on valid beats; ack arrives after 8 valid beats; no early ack.
REQ-039 Reset asserted at beat 4 of a read:
- state goes to IDLE next cycle, no ack, line_rdata=0.
- a following request completes normally.
REQ-040 mem_ready held low in ADDR for 5 cycles: mem_req and mem_addr stay stable; the late-arriving dc_req waits and is granted after ic_ack.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Client, memory and status signals of the I-cache/D-cache memory port arbiter.
// slave: the arbiter side. master: the clients plus the backing memory.
interface mem_port_arbiter_if;
    logic         ic_req;
    logic [57:0]  ic_line_addr;
    logic         ic_ack;
    logic         dc_req;
    logic [57:0]  dc_line_addr;
    logic         dc_write;
    logic [511:0] dc_wline;
    logic         dc_ack;
    logic [511:0] line_rdata;
    logic         mem_req;
    logic [63:0]  mem_addr;
    logic         mem_we;
    logic         mem_ready;
    logic [63:0]  mem_wdata;
    logic         mem_rvalid;
    logic [63:0]  mem_rdata;
    logic         busy;

    modport slave (
        input  ic_req, ic_line_addr, dc_req, dc_line_addr, dc_write, dc_wline,
               mem_ready, mem_rvalid, mem_rdata,
        output ic_ack, dc_ack, line_rdata, mem_req, mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output ic_req, ic_line_addr, dc_req, dc_line_addr, dc_write, dc_wline,
               mem_ready, mem_rvalid, mem_rdata,
        input  ic_ack, dc_ack, line_rdata, mem_req, mem_addr, mem_we, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 64-bit memory port between the I-cache and
// D-cache. Every transaction is an address phase followed by an 8-beat burst of
// a 64-byte line, then a one-cycle ack to the granted client.
module mem_port_arbiter (
    input logic          clk,
    input logic          reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_BEAT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [2:0]   r_cnt;
    logic         r_grant_dc;   // client owning the current transaction
    logic         r_last_dc;    // client served last, resets to IC
    logic [57:0]  r_addr;
    logic         r_we;
    logic [511:0] r_wline;
    logic [511:0] r_rdata;

    logic         w_grant;
    logic         w_pick_dc;
    logic         w_beat;
    logic [8:0]   w_slice;

    // DC wins when it is alone, or on a tie when IC was served last
    assign w_pick_dc = bus.dc_req && (!bus.ic_req || !r_last_dc);
    assign w_slice   = {r_cnt, 6'b0};

    // next-state and per-cycle control decode
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ic_req || bus.dc_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.mem_ready) w_state_nxt = S_BEAT;
            end
            S_BEAT: begin
                w_beat = r_we ? bus.mem_ready : bus.mem_rvalid;
                if (w_beat && (r_cnt == 3'd7)) w_state_nxt = S_RESP;
            end
            S_RESP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // transaction latch, beat counter and fill-line assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= 3'd0;
            r_grant_dc <= 1'b0;
            r_last_dc  <= 1'b0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wline    <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_grant) begin
                r_grant_dc <= w_pick_dc;
                r_last_dc  <= w_pick_dc;
                r_addr     <= w_pick_dc ? bus.dc_line_addr : bus.ic_line_addr;
                r_we       <= w_pick_dc & bus.dc_write;
                r_wline    <= w_pick_dc ? bus.dc_wline : '0;
                r_cnt      <= 3'd0;
            end
            if (w_beat) begin
                if (!r_we) r_rdata[w_slice +: 64] <= bus.mem_rdata;
                // stop at 7 so the wrap never shows on mem_wdata during RESP
                if (r_cnt != 3'd7) r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    assign bus.mem_req    = (r_state == S_ADDR);
    assign bus.mem_addr   = {r_addr, 6'b0};
    assign bus.mem_we     = r_we;
    assign bus.mem_wdata  = r_wline[w_slice +: 64];
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.ic_ack     = (r_state == S_RESP) && !r_grant_dc;
    assign bus.dc_ack     = (r_state == S_RESP) &&  r_grant_dc;
    assign bus.line_rdata = r_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random
// phase, checked against a transaction-level memory model and client model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    mem_port_arbiter_if bus();

    mem_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // backing memory: 64-bit words by byte address
    logic [63:0] mem [logic [63:0]];

    // memory-side protocol tracker
    bit          in_burst = 0;
    bit          burst_we = 0;
    logic [63:0] burst_addr = '0;
    int          beats = 0;
    int          last_beat_cyc = -1;
    int          ready_mode = 0;
    int          rvalid_mode = 0;
    int          addr_cnt = 0;
    logic        p_req = 0, p_ready = 0, p_rvalid = 0, p_we = 0;
    logic [63:0] p_addr = '0, p_wdata = '0;

    // client model
    bit           ic_pend = 0, dc_pend = 0;
    logic [57:0]  ic_addr_t = '0, dc_addr_t = '0;
    logic         dc_wr_t = 0;
    logic [511:0] dc_wl_t = '0;
    int           ack_who[$];
    int           ack_cyc[$];

    function automatic logic [63:0] memrd(logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
    endfunction

    function automatic logic [511:0] line_of(logic [57:0] la);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = memrd({la, 6'b0} + 64'(8*k));
        return l;
    endfunction

    task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_ic(logic [57:0] a);
        ic_addr_t = a; bus.ic_line_addr = a; bus.ic_req = 1'b1; ic_pend = 1;
    endtask

    task automatic issue_dc(logic [57:0] a, logic w, logic [511:0] wl);
        dc_addr_t = a; dc_wr_t = w; dc_wl_t = wl;
        bus.dc_line_addr = a; bus.dc_write = w; bus.dc_wline = wl;
        bus.dc_req = 1'b1; dc_pend = 1;
    endtask

    // one clock: account for what the edge consumed, check, drive next inputs
    task automatic step();
        logic r, v;
        @(posedge clk); #1; cyc++;
        if (reset) begin
            in_burst = 0;
        end else begin
            if (p_req && p_ready) begin
                in_burst = 1; beats = 0; burst_we = p_we; burst_addr = p_addr;
            end else if (in_burst) begin
                if (burst_we) begin
                    if (p_ready) begin
                        chk("wbeat", p_wdata, dc_wl_t[64*beats +: 64]);
                        mem[burst_addr + 64'(8*beats)] = dc_wl_t[64*beats +: 64];
                        beats++;
                    end else begin
                        chk("whold", bus.mem_wdata, p_wdata);
                    end
                end else if (p_rvalid) begin
                    beats++;
                end
                if (beats == 8) begin in_burst = 0; last_beat_cyc = cyc; end
            end
            if (p_req && !p_ready) begin
                chk("addr_hold_req", bus.mem_req, 1);
                chk("addr_hold_addr", bus.mem_addr, p_addr);
                chk("addr_hold_we", bus.mem_we, p_we);
            end
        end
        chk("ack_excl", bus.ic_ack & bus.dc_ack, 0);
        chk("req_busy", bus.mem_req & ~bus.busy, 0);
        if (bus.ic_ack) begin
            chk("ic_ack_pend", ic_pend, 1);
            chk("ic_ack_time", cyc, last_beat_cyc);
            chk("ic_addr", burst_addr, {ic_addr_t, 6'b0});
            chk("ic_we", burst_we, 0);
            chk("ic_line", bus.line_rdata, line_of(ic_addr_t));
            ack_who.push_back(0); ack_cyc.push_back(cyc);
            ic_pend = 0; bus.ic_req = 1'b0;
        end
        if (bus.dc_ack) begin
            chk("dc_ack_pend", dc_pend, 1);
            chk("dc_ack_time", cyc, last_beat_cyc);
            chk("dc_addr", burst_addr, {dc_addr_t, 6'b0});
            chk("dc_we", burst_we, dc_wr_t);
            if (!dc_wr_t) chk("dc_line", bus.line_rdata, line_of(dc_addr_t));
            ack_who.push_back(1); ack_cyc.push_back(cyc);
            dc_pend = 0; bus.dc_req = 1'b0;
        end
        if (bus.mem_req) addr_cnt++; else addr_cnt = 0;
        case (ready_mode)
            0: r = 1'b1;
            1: r = ((cyc % 2) == 0);
            2: r = 1'($urandom);
            default: r = !bus.mem_req || (addr_cnt >= 6);
        endcase
        if (in_burst && !burst_we) begin
            case (rvalid_mode)
                0: v = 1'b1;
                1: v = ((cyc % 3) == 0);
                default: v = 1'($urandom);
            endcase
            bus.mem_rdata = memrd(burst_addr + 64'(8*beats));
        end else begin
            v = 1'($urandom);
            bus.mem_rdata = {$urandom, $urandom};
        end
        bus.mem_ready = r; bus.mem_rvalid = v;
        p_req = bus.mem_req; p_ready = r; p_rvalid = v; p_we = bus.mem_we;
        p_addr = bus.mem_addr; p_wdata = bus.mem_wdata;
    endtask

    task automatic wait_acks(int n, int budget, string tag);
        int i = 0;
        while (ack_who.size() < n && i < budget) begin step(); i++; end
        chk(tag, ack_who.size() >= n, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ic_req = 1'b0; bus.dc_req = 1'b0; ic_pend = 0; dc_pend = 0;
        step(); step();
        reset = 1'b0;
        in_burst = 0; beats = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, n, issued;
        logic [511:0] wl;
        bus.ic_req = 0; bus.ic_line_addr = '0; bus.dc_req = 0; bus.dc_line_addr = '0;
        bus.dc_write = 0; bus.dc_wline = '0; bus.mem_ready = 0; bus.mem_rvalid = 0;
        bus.mem_rdata = '0;

        // reset state
        step(); step(); step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_ic_ack", bus.ic_ack, 0);
        chk("rst_dc_ack", bus.dc_ack, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_line", bus.line_rdata, 0);
        reset = 1'b0;
        step();

        // IC read of line 1, memory always ready/valid, rdata = beat index
        for (int k = 0; k < 8; k++) mem[64'h40 + 64'(8*k)] = 64'(k);
        ready_mode = 0; rvalid_mode = 0;
        issue_ic(58'h1);
        b = cyc;
        step();
        chk("t1_mem_req", bus.mem_req, 1);
        chk("t1_mem_addr", bus.mem_addr, 64'h40);
        chk("t1_mem_we", bus.mem_we, 0);
        chk("t1_busy", bus.busy, 1);
        wait_acks(1, 40, "t1_ack_seen");
        chk("t1_latency", ack_cyc[0] - b, 10);
        for (int k = 0; k < 8; k++) chk("t1_beat", bus.line_rdata[64*k +: 64], 64'(k));
        step();
        chk("t1_idle", bus.busy, 0);

        // DC writeback of line 3, ready low every other cycle
        for (int k = 0; k < 8; k++) wl[64*k +: 64] = 64'h A0 + 64'(k);
        ready_mode = 1;
        issue_dc(58'h3, 1'b1, wl);
        step();
        chk("t2_mem_we", bus.mem_we, 1);
        chk("t2_mem_addr", bus.mem_addr, 64'hC0);
        wait_acks(2, 60, "t2_ack_seen");
        chk("t2_who", ack_who[1], 1);
        // read it back through the I-cache
        ready_mode = 0;
        step();
        issue_ic(58'h3);
        wait_acks(3, 40, "t2_readback");
        chk("t2_rb_beat0", bus.line_rdata[63:0], 64'hA0);
        chk("t2_rb_beat7", bus.line_rdata[511:448], 64'hA7);

        // simultaneous requests after reset: DC first, then IC, twice
        do_reset();
        step();
        b = ack_who.size();
        issue_dc(58'h5, 1'b0, '0); issue_ic(58'h6);
        wait_acks(b + 2, 60, "t3_pair1");
        chk("t3_first", ack_who[b], 1);
        chk("t3_second", ack_who[b+1], 0);
        chk("t3_no_dead", ack_cyc[b+1] - ack_cyc[b], 11);
        step();
        issue_dc(58'h7, 1'b0, '0); issue_ic(58'h8);
        wait_acks(b + 4, 60, "t3_pair2");
        chk("t3_third", ack_who[b+2], 1);
        chk("t3_fourth", ack_who[b+3], 0);

        // rvalid only every third cycle
        rvalid_mode = 1;
        step();
        b = ack_who.size();
        issue_ic(58'h20);
        wait_acks(b + 1, 80, "t4_ack_seen");
        rvalid_mode = 0;

        // reset at beat 4 of a read aborts without ack
        step();
        issue_ic(58'h9);
        n = 0;
        while (!(in_burst && beats == 4) && n < 30) begin step(); n++; end
        chk("t5_reached_beat4", in_burst && beats == 4, 1);
        b = ack_who.size();
        reset = 1'b1; bus.ic_req = 1'b0; ic_pend = 0;
        step();
        reset = 1'b0; in_burst = 0; beats = 0;
        chk("t5_busy", bus.busy, 0);
        chk("t5_line", bus.line_rdata, 0);
        chk("t5_mem_req", bus.mem_req, 0);
        step(); step(); step();
        chk("t5_no_ack", ack_who.size(), b);
        issue_ic(58'hA);
        wait_acks(b + 1, 40, "t5_after");

        // ready low for 5 ADDR cycles; requester inputs change; late dc_req waits
        ready_mode = 3;
        step();
        b = ack_who.size();
        issue_ic(58'h11);
        step();
        bus.ic_line_addr = 58'h3FF;
        issue_dc(58'h12, 1'b0, '0);
        step(); step(); step();
        chk("t6_req_stable", bus.mem_req, 1);
        chk("t6_addr_stable", bus.mem_addr, {58'h11, 6'b0});
        wait_acks(b + 2, 80, "t6_acks");
        chk("t6_first_ic", ack_who[b], 0);
        chk("t6_then_dc", ack_who[b+1], 1);

        // random traffic on both clients
        ready_mode = 2; rvalid_mode = 2;
        b = ack_who.size();
        issued = 0;
        for (int i = 0; i < 400; i++) begin
            if (!ic_pend && !bus.ic_req && ($urandom % 4 == 0)) begin
                issue_ic(58'($urandom % 16)); issued++;
            end
            if (!dc_pend && !bus.dc_req && ($urandom % 4 == 0)) begin
                for (int k = 0; k < 16; k++) wl[32*k +: 32] = $urandom;
                issue_dc(58'($urandom % 16), 1'($urandom), wl); issued++;
            end
            step();
        end
        wait_acks(b + issued, 2000, "rand_all_acked");
        chk("rand_count", ack_who.size() - b, issued);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
